// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared constants for the FIFO-drain UART transmitter.
// Holds the FSM state encoding and the serial line levels used by fifo_uart_tx.
package fifo_uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clock cycles within one serial bit period.
// Ports:
//   clk        clock, state on rising edge
//   reset_n    asynchronous active-low reset
//   clear      forces the count back to zero on the next edge
//   last_tick  high in the final cycle of the bit period (count == CLKS_PER_BIT-1)
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic last_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last_tick = (count_q == LAST);

    // Restart at zero after the terminal count so consecutive bits in the
    // same state get identical periods without needing a clear.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || last_tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO and sends each word as an
// asynchronous serial frame: start bit, DATA_W data bits LSB first, optional
// even-parity bit, stop bit.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   enable         allows new frames to start; a frame in flight always completes
//   fifo_empty     FIFO empty flag
//   fifo_data      FIFO head word, valid while fifo_empty is low
//   fifo_pop       combinational one-cycle pop, one per transmitted word
//   tx             registered serial output, idle high
//   busy           high from the cycle after the pop until the frame ends
//   frame_done     one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic [2:0]        state_q,  state_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic              parity_q, parity_d;
    logic [BW-1:0]     bitIdx_q, bitIdx_d;
    logic              tx_q,     tx_d;
    logic              lastTick;
    logic              timerClear;
    logic              popNow;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (timerClear),
        .last_tick(lastTick)
    );

    // A pop is only legal when idle or in the very last stop cycle, which is
    // what gives gap-free back-to-back frames. reset_n gates it so the FIFO
    // is never drained while the transmitter is held in reset.
    assign popNow = reset_n & enable & ~fifo_empty &
                    ((state_q == IDLE) | ((state_q == STOP) & lastTick));

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        bitIdx_d = bitIdx_q;
        if (popNow) begin
            shift_d  = fifo_data;
            parity_d = ^fifo_data;
            bitIdx_d = '0;
            state_d  = START;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                START:   if (lastTick) state_d = DATA;
                DATA: begin
                    if (lastTick) begin
                        shift_d = shift_q >> 1;
                        if (bitIdx_q == LAST_BIT) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bitIdx_d = bitIdx_q + BW'(1);
                        end
                    end
                end
                PARITY:  if (lastTick) state_d = STOP;
                STOP:    if (lastTick) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // tx is derived from the next state so the registered line changes on
    // the same edge the FSM enters each bit.
    always_comb begin
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = TX_IDLE;
        endcase
    end

    assign timerClear = (state_q == IDLE) | (state_d != state_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bitIdx_q <= '0;
            tx_q     <= TX_IDLE;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            bitIdx_q <= bitIdx_d;
            tx_q     <= tx_d;
        end
    end

    assign fifo_pop   = popNow;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) & lastTick;

endmodule
